// File: rtl/mips_ctrl_pkg.sv
// Shared control-path definitions for the MIPS fetch/decode front end:
// branch condition codes, sequencer state encoding and reset defaults.
package mips_ctrl_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned JIDX_W            = 26;
  localparam int unsigned CNT_WIDTH_DEFAULT = 16;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] BC_EQ     = 3'b000;
  localparam logic [2:0] BC_REGIMM = 3'b001;
  localparam logic [2:0] BC_GTZ    = 3'b010;
  localparam logic [2:0] BC_LEZ    = 3'b011;
  localparam logic [2:0] BC_NE     = 3'b101;

  typedef enum logic [0:0] {
    SEQ_BOOT = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  // J/JAL target: region bits of PC+4 with the word-aligned instruction index
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc4,
                                                   input logic [JIDX_W-1:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Flow-control bundle between the ID-stage controller/datapath and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 16
) ();

  logic                 Stall;
  logic                 DecodeValid;
  logic                 Branch;
  logic                 Jump;
  logic                 JumpMux;
  logic                 JAL;
  logic                 BranchSourceMux;
  logic [2:0]           BCControl;
  logic                 RegimmRt0;
  logic [31:0]          RsData;
  logic [31:0]          RtData;
  logic [31:0]          BranchOffset;
  logic [25:0]          JumpIndex;
  logic [31:0]          IdPC4;
  logic                 CountClear;

  logic [31:0]          PC;
  logic                 PCValid;
  logic                 IfIdFlush;
  logic                 Taken;
  logic [31:0]          LinkAddr;
  logic                 LinkWrite;
  logic [CNT_WIDTH-1:0] BranchCount;
  logic [CNT_WIDTH-1:0] TakenCount;

  modport master (
    output Stall, DecodeValid, Branch, Jump, JumpMux, JAL, BranchSourceMux,
           BCControl, RegimmRt0, RsData, RtData, BranchOffset, JumpIndex,
           IdPC4, CountClear,
    input  PC, PCValid, IfIdFlush, Taken, LinkAddr, LinkWrite,
           BranchCount, TakenCount
  );

  modport slave (
    input  Stall, DecodeValid, Branch, Jump, JumpMux, JAL, BranchSourceMux,
           BCControl, RegimmRt0, RsData, RtData, BranchOffset, JumpIndex,
           IdPC4, CountClear,
    output PC, PCValid, IfIdFlush, Taken, LinkAddr, LinkWrite,
           BranchCount, TakenCount
  );

endinterface

// File: rtl/branch_condition_unit.sv
// Combinational branch condition evaluation; A is the signed rs operand, B is rt.
module branch_condition_unit
  import mips_ctrl_pkg::*;
(
  input  logic [2:0]      BCControl,
  input  logic            RegimmRt0,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            CondTrue
);

  always_comb begin
    CondTrue = 1'b0;
    case (BCControl)
      BC_EQ:     CondTrue = (A == B);
      BC_NE:     CondTrue = (A != B);
      BC_GTZ:    CondTrue = ($signed(A) > $signed(32'sd0));
      BC_LEZ:    CondTrue = ($signed(A) <= $signed(32'sd0));
      // rt[0]=1 is BGEZ, rt[0]=0 is BLTZ; only the sign bit matters
      BC_REGIMM: CondTrue = RegimmRt0 ? ~A[XLEN-1] : A[XLEN-1];
      default:   CondTrue = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: owns the PC, resolves ID-stage branch/jump redirects,
// flushes the wrong-path IF/ID entry, emits the JAL link write and branch statistics.
module pc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
  input  logic          Clock,
  input  logic          Reset,
  pc_sequencer_if.slave bus
);

  seq_state_e state_q, state_d;
  logic       run_c;

  logic [XLEN-1:0]      pc_q, pc_d;
  logic                 taken_q, taken_d;
  logic [XLEN-1:0]      link_addr_q, link_addr_d;
  logic                 link_write_q, link_write_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  logic            cond_true_c;
  logic            cond_ok_c;
  logic            decide_c;
  logic            redirect_c;
  logic            br_count_c;
  logic            tk_count_c;
  logic [XLEN-1:0] target_c;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= SEQ_BOOT;
    else       state_q <= state_d;
  end

  // Next state: BOOT lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_BOOT: state_d = SEQ_RUN;
      SEQ_RUN:  state_d = SEQ_RUN;
      default:  state_d = SEQ_BOOT;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    run_c = 1'b0;
    case (state_q)
      SEQ_RUN: run_c = 1'b1;
      default: run_c = 1'b0;
    endcase
  end

  branch_condition_unit u_bcu (
    .BCControl (bus.BCControl),
    .RegimmRt0 (bus.RegimmRt0),
    .A         (bus.RsData),
    .B         (bus.RtData),
    .CondTrue  (cond_true_c)
  );

  // A REGIMM code without the zero-compare source selected is malformed; treat as not taken
  assign cond_ok_c = cond_true_c & ((bus.BCControl != BC_REGIMM) | bus.BranchSourceMux);

  assign decide_c   = run_c & bus.DecodeValid & ~bus.Stall;
  assign redirect_c = bus.Jump | (bus.Branch & cond_ok_c);
  assign br_count_c = decide_c & bus.Branch & ~bus.Jump;
  assign tk_count_c = br_count_c & cond_ok_c;

  // Jump outranks branch, so a malformed Branch+Jump still goes to the jump target
  always_comb begin
    target_c = bus.IdPC4 + (bus.BranchOffset << 2);
    if (bus.Jump) begin
      target_c = bus.JumpMux ? bus.RsData : jump_target(bus.IdPC4, bus.JumpIndex);
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (run_c && !bus.Stall) begin
      pc_d = (decide_c && redirect_c) ? target_c : pc_q + XLEN'(4);
    end

    taken_d      = decide_c & redirect_c;
    link_write_d = decide_c & bus.Jump & bus.JAL;
    link_addr_d  = link_write_d ? bus.IdPC4 : link_addr_q;

    // Clear wins over increment; increments saturate at all-ones
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (bus.CountClear) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
    end else begin
      if (br_count_c && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      if (tk_count_c && (taken_cnt_q  != '1)) taken_cnt_d  = taken_cnt_q  + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q         <= RESET_VECTOR;
      taken_q      <= 1'b0;
      link_addr_q  <= '0;
      link_write_q <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      taken_q      <= taken_d;
      link_addr_q  <= link_addr_d;
      link_write_q <= link_write_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PCValid     = run_c;
  assign bus.IfIdFlush   = decide_c & redirect_c;
  assign bus.Taken       = taken_q;
  assign bus.LinkAddr    = link_addr_q;
  assign bus.LinkWrite   = link_write_q;
  assign bus.BranchCount = branch_cnt_q;
  assign bus.TakenCount  = taken_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer: one record per clock cycle,
// flush sampled before the edge, registered outputs checked just after it.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_WIDTH(16)) bus ();

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .CNT_WIDTH    (16)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        rst, stall, dv, br, jmp, jmux, jal, bsm;
    logic [2:0]  bc;
    logic        rt0, clr;
    logic [31:0] rs, rt, off, idpc4;
    logic [25:0] jidx;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_valid, e_taken, e_lw;
    logic [31:0] e_la;
    logic [15:0] e_bc, e_tc;
  } vec_t;

  int vectors    = 0;
  int miscompares = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input string n, input logic r, input logic st, input logic dv, input logic br,
    input logic jm, input logic jmx, input logic jl, input logic bsm, input logic [2:0] bc,
    input logic rt0, input logic clr, input logic [31:0] rs, input logic [31:0] rt,
    input logic [31:0] off, input logic [31:0] pc4, input logic [25:0] jidx,
    input logic ef, input logic [31:0] epc, input logic ev, input logic et, input logic elw,
    input logic [31:0] ela, input logic [15:0] ebc, input logic [15:0] etc_);
    vec_t v;
    v.name = n; v.rst = r; v.stall = st; v.dv = dv; v.br = br; v.jmp = jm; v.jmux = jmx;
    v.jal = jl; v.bsm = bsm; v.bc = bc; v.rt0 = rt0; v.clr = clr; v.rs = rs; v.rt = rt;
    v.off = off; v.idpc4 = pc4; v.jidx = jidx; v.e_flush = ef; v.e_pc = epc; v.e_valid = ev;
    v.e_taken = et; v.e_lw = elw; v.e_la = ela; v.e_bc = ebc; v.e_tc = etc_;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst                 = v.rst;
    bus.Stall           = v.stall;
    bus.DecodeValid     = v.dv;
    bus.Branch          = v.br;
    bus.Jump            = v.jmp;
    bus.JumpMux         = v.jmux;
    bus.JAL             = v.jal;
    bus.BranchSourceMux = v.bsm;
    bus.BCControl       = v.bc;
    bus.RegimmRt0       = v.rt0;
    bus.CountClear      = v.clr;
    bus.RsData          = v.rs;
    bus.RtData          = v.rt;
    bus.BranchOffset    = v.off;
    bus.IdPC4           = v.idpc4;
    bus.JumpIndex       = v.jidx;
  endtask

  task automatic check(input vec_t v, input logic flush_s);
    vectors++;
    if (flush_s !== v.e_flush || bus.PC !== v.e_pc || bus.PCValid !== v.e_valid ||
        bus.Taken !== v.e_taken || bus.LinkWrite !== v.e_lw || bus.LinkAddr !== v.e_la ||
        bus.BranchCount !== v.e_bc || bus.TakenCount !== v.e_tc) begin
      miscompares++;
      $display("FAIL %s: got flush=%b pc=%h valid=%b taken=%b lw=%b la=%h bcnt=%0d tcnt=%0d | want flush=%b pc=%h valid=%b taken=%b lw=%b la=%h bcnt=%0d tcnt=%0d",
               v.name, flush_s, bus.PC, bus.PCValid, bus.Taken, bus.LinkWrite, bus.LinkAddr,
               bus.BranchCount, bus.TakenCount, v.e_flush, v.e_pc, v.e_valid, v.e_taken,
               v.e_lw, v.e_la, v.e_bc, v.e_tc);
    end
  endtask

  // One cycle: inputs at negedge, combinational flush just after, registered outputs after posedge
  task automatic run_vec(input vec_t v, input bit do_check);
    logic flush_s;
    @(negedge clk);
    drive(v);
    #1 flush_s = bus.IfIdFlush;
    @(posedge clk);
    #1;
    if (do_check) check(v, flush_s);
  endtask

  localparam logic [31:0] LA = 32'h4000_0010;

  initial begin
    vec_t sat_br;
    //           name        rst st dv br jm jx jl bs bc      r0 cl rs            rt      off           idpc4         jidx          fl pc            v  t  lw la     bcnt     tcnt
    tbl.push_back(mk("reset",    1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h0,        0, 0, 0, 32'h0, 16'd0, 16'd0));
    tbl.push_back(mk("boot",     0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h0,        1, 0, 0, 32'h0, 16'd0, 16'd0));
    tbl.push_back(mk("seq4",     0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h4,        1, 0, 0, 32'h0, 16'd0, 16'd0));
    tbl.push_back(mk("seq8",     0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h8,        1, 0, 0, 32'h0, 16'd0, 16'd0));
    tbl.push_back(mk("beq_tk",   0, 0, 1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 32'd5,        32'd5,  32'hFFFF_FFFE, 32'h100,     26'h0,        1, 32'hF8,       1, 1, 0, 32'h0, 16'd1, 16'd1));
    tbl.push_back(mk("idle_fc",  0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'hFC,       1, 0, 0, 32'h0, 16'd1, 16'd1));
    tbl.push_back(mk("clear",    0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h100,      1, 0, 0, 32'h0, 16'd0, 16'd0));
    tbl.push_back(mk("bltz_nt",  0, 0, 1, 1, 0, 0, 0, 1, 3'b001, 0, 0, 32'h0,        32'h0,  32'd4,        32'h104,      26'h0,        0, 32'h104,      1, 0, 0, 32'h0, 16'd1, 16'd0));
    tbl.push_back(mk("bgez_tk",  0, 0, 1, 1, 0, 0, 0, 1, 3'b001, 1, 0, 32'h0,        32'h0,  32'd4,        32'h104,      26'h0,        1, 32'h114,      1, 1, 0, 32'h0, 16'd2, 16'd1));
    tbl.push_back(mk("bne_nt",   0, 0, 1, 1, 0, 0, 0, 0, 3'b101, 0, 0, 32'd3,        32'd3,  32'd8,        32'h118,      26'h0,        0, 32'h118,      1, 0, 0, 32'h0, 16'd3, 16'd1));
    tbl.push_back(mk("bgtz_tk",  0, 0, 1, 1, 0, 0, 0, 0, 3'b010, 0, 0, 32'd1,        32'h0,  32'd1,        32'h11C,      26'h0,        1, 32'h120,      1, 1, 0, 32'h0, 16'd4, 16'd2));
    tbl.push_back(mk("blez_neg", 0, 0, 1, 1, 0, 0, 0, 0, 3'b011, 0, 0, 32'h8000_0000, 32'h0, 32'hFFFF_FFFC, 32'h124,     26'h0,        1, 32'h114,      1, 1, 0, 32'h0, 16'd5, 16'd3));
    tbl.push_back(mk("bad_code", 0, 0, 1, 1, 0, 0, 0, 0, 3'b111, 0, 0, 32'h0,        32'h0,  32'h10,       32'h118,      26'h0,        0, 32'h118,      1, 0, 0, 32'h0, 16'd6, 16'd3));
    tbl.push_back(mk("bubble",   0, 0, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h7,        32'h7,  32'h10,       32'h200,      26'h0,        0, 32'h11C,      1, 0, 0, 32'h0, 16'd6, 16'd3));
    tbl.push_back(mk("jal",      0, 0, 1, 0, 1, 0, 1, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        LA,           26'h40,       1, 32'h4000_0100, 1, 1, 1, LA,   16'd6, 16'd3));
    tbl.push_back(mk("jal_after",0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h4000_0104, 1, 0, 0, LA,   16'd6, 16'd3));
    tbl.push_back(mk("jr_stall1",0, 1, 1, 0, 1, 1, 0, 0, 3'b000, 0, 0, 32'h200,      32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h4000_0104, 1, 0, 0, LA,   16'd6, 16'd3));
    tbl.push_back(mk("jr_stall2",0, 1, 1, 0, 1, 1, 0, 0, 3'b000, 0, 0, 32'h200,      32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h4000_0104, 1, 0, 0, LA,   16'd6, 16'd3));
    tbl.push_back(mk("jr_go",    0, 0, 1, 0, 1, 1, 0, 0, 3'b000, 0, 0, 32'h200,      32'h0,  32'h0,        32'h0,        26'h0,        1, 32'h200,      1, 1, 0, LA,   16'd6, 16'd3));
    tbl.push_back(mk("jr_after", 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h204,      1, 0, 0, LA,   16'd6, 16'd3));
    tbl.push_back(mk("j_and_br", 0, 0, 1, 1, 1, 0, 0, 0, 3'b000, 0, 0, 32'h9,        32'h9,  32'h40,       32'h1234_5678, 26'h3FF_FFFF, 1, 32'h1FFF_FFFC, 1, 1, 0, LA,  16'd6, 16'd3));
    tbl.push_back(mk("jr_top",   0, 0, 1, 0, 1, 1, 0, 0, 3'b000, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0,        32'h0,        26'h0,        1, 32'hFFFF_FFFC, 1, 1, 0, LA,  16'd6, 16'd3));
    tbl.push_back(mk("pc_wrap",  0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h0,        1, 0, 0, LA,   16'd6, 16'd3));
    tbl.push_back(mk("rst_redir",1, 0, 1, 0, 1, 1, 0, 0, 3'b000, 0, 0, 32'h300,      32'h0,  32'h0,        32'h0,        26'h0,        1, 32'h0,        0, 0, 0, 32'h0, 16'd0, 16'd0));
    tbl.push_back(mk("reboot",   0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h0,        1, 0, 0, 32'h0, 16'd0, 16'd0));
    tbl.push_back(mk("reseq4",   0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,  32'h0,        32'h0,        26'h0,        0, 32'h4,        1, 0, 0, 32'h0, 16'd0, 16'd0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 1'b1);

    // Counter saturation: 65535 taken BEQs to 0x10, then one more, then one with clear
    sat_br = mk("sat_fill", 0, 0, 1, 1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h1, 32'h1, 32'h0, 32'h10, 26'h0,
                1, 32'h10, 1, 1, 0, 32'h0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 65535; i++) run_vec(sat_br, 1'b0);
    sat_br.name = "sat_hold";
    run_vec(sat_br, 1'b1);
    sat_br.name  = "clr_beats_inc";
    sat_br.clr   = 1'b1;
    sat_br.e_bc  = 16'd0;
    sat_br.e_tc  = 16'd0;
    run_vec(sat_br, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program counter sequencer for the pipelined MIPS core. It is the consumer of the datapath controller's flow-control outputs: `Branch`, `BCControl`, `BranchSourceMux`, `Jump`, `JumpMux` and `JAL`. It owns the PC register, resolves branch and jump redirects for the instruction in ID, flushes the wrong-path IF/ID entry, and produces the link write for JAL. It also keeps saturating branch statistics for the debug display.

## Interface
- `RESET_VECTOR`, 32'h0000_0000: PC loaded on reset.
- `CNT_WIDTH`, 16: width of the statistics counters.

- `Clock` in 1: rising-edge clock.
- `Reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `Stall` in 1: hazard stall. Holds the PC and defers any ID decision.
- `DecodeValid` in 1: the ID stage holds a real, non-flushed instruction.
- `Branch`, `Jump`, `JumpMux`, `JAL`, `BranchSourceMux` in 1 each: controller outputs for the instruction in ID.
- `BCControl` in 3: branch condition code.
- `RegimmRt0` in 1: bit 0 of the rt field. 1 selects BGEZ, 0 selects BLTZ.
- `RsData`, `RtData` in 32: forwarded register operands.
- `BranchOffset` in 32: sign-extended immediate.
- `JumpIndex` in 26: instr[25:0].
- `IdPC4` in 32: PC+4 of the instruction in ID.
- `CountClear` in 1: clears the statistics counters.
- `PC` out 32: fetch address.
- `PCValid` out 1: `PC` is a real fetch address.
- `IfIdFlush` out 1: combinational; squash the IF/ID latch at this edge.
- `Taken` out 1: registered; the redirect decided in the previous cycle.
- `LinkAddr` out 32, `LinkWrite` out 1: registered JAL link value and its one-cycle write strobe.
- `BranchCount`, `TakenCount` out `CNT_WIDTH`: statistics.

## Operation
- **States:** BOOT and RUN.
  - Reset forces BOOT: `PC`=`RESET_VECTOR`, `PCValid`=0, `Taken`=0, `LinkWrite`=0, `LinkAddr`=0, counters=0.
  - BOOT goes to RUN after one cycle. `PC` holds and `PCValid` rises entering RUN.
- **Decision:** `Decide` = RUN & `DecodeValid` & !`Stall`.
- **Redirect priority:** Jump first, then Branch. Both set together is illegal but resolves as a jump.
  - `Jump` & `JumpMux` (JR): target = `RsData`.
  - `Jump` & !`JumpMux` (J/JAL): target = {`IdPC4`[31:28], `JumpIndex`, 2'b00}.
  - `Branch` & condition true: target = `IdPC4` + (`BranchOffset` << 2), modulo 2^32.
- **Branch conditions** (A = `RsData` signed, B = `RtData`):
  - 000 BEQ: A==B.
  - 101 BNE: A!=B.
  - 010 BGTZ: A>0.
  - 011 BLEZ: A<=0.
  - 001 REGIMM: `RegimmRt0` ? A>=0 : A<0. `BranchSourceMux` must be 1 with this code.
  - Other codes: condition false.
- **PC update in RUN:**
  - `Stall`: hold.
  - Else if `Decide` & redirect: `PC` <= target.
  - Else: `PC` <= `PC`+4, wrapping FFFF_FFFC to 0000_0000.
- **Delay slot:** none. `IfIdFlush` = `Decide` & redirect.
- **JAL:** when `Decide` & `Jump` & `JAL`, next cycle `LinkAddr`=`IdPC4` and `LinkWrite`=1 for one cycle.
- **Counters:**
  - `BranchCount`++ on `Decide` & `Branch` & !`Jump`.
  - `TakenCount`++ when that branch is also taken.
  - Both saturate at all-ones.
  - `CountClear` clears both and beats a simultaneous increment. `Reset` beats everything.

## Timing
- Redirect latency: decision in cycle N, target on `PC` in N+1.
- `IfIdFlush` is high in cycle N only.
- `Taken`, `LinkWrite`: pulse in N+1.
- `Stall` high in the decision cycle: no flush, no count, no `LinkWrite`. The decision re-evaluates in the first unstalled cycle; upstream holds its inputs.
- `Reset` asserted mid-redirect: the pending target is discarded, `PC`=`RESET_VECTOR` next cycle, BOOT re-entered.
- `DecodeValid`=0 (a flushed bubble): sequential fetch, no side effects.

## Structure
- **Shared package `mips_ctrl_pkg`:**
  - BCControl codes `BC_EQ`=3'b000, `BC_REGIMM`=3'b001, `BC_GTZ`=3'b010, `BC_LEZ`=3'b011, `BC_NE`=3'b101.
  - State encoding.
  - `RESET_VECTOR` default.
- **Sub-module:** combinational `branch_condition_unit` (`BCControl`, `RegimmRt0`, A, B -> `CondTrue`), shared with any future early-branch logic.

## Test plan
- Reset, then 3 unstalled cycles with `DecodeValid`=0 -> `PC` = 0, 0 (BOOT), 4, 8; `PCValid` 0,1,1,1.
- BEQ, `RsData`=`RtData`=5, `IdPC4`=0x100, `BranchOffset`=-2 -> `IfIdFlush`=1 that cycle, next `PC`=0xF8, `Taken`=1, `BranchCount`=`TakenCount`=1.
- BLTZ (`BCControl`=001, `RegimmRt0`=0), `RsData`=0 -> not taken, `PC`+4, `BranchCount`=1, `TakenCount`=0. Repeat with `RegimmRt0`=1 -> taken.
- JAL, `IdPC4`=0x4000_0010, `JumpIndex`=0x000_0040 -> next `PC`=0x4000_0100, `LinkWrite` 1-cycle pulse, `LinkAddr`=0x4000_0010.
- JR with `Stall`=1 for 2 cycles, then 0, `RsData`=0x200 -> `PC` held 2 cycles, single `IfIdFlush`, then `PC`=0x200.
- `TakenCount` preset by 65535 taken branches, then one more taken branch with `CountClear`=1 -> both counters 0. Also: `PC`=0xFFFF_FFFC sequential -> 0.
